sumador_serial: RTL

SUMADOR_SERIAL -- requirements
Module: sumador_serial

---
 rtl/sumador_serial.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sumador_serial.sv
// -----------------------------------------------------------------------------
// sumador_serial
//
// Serial two's-complement adder/subtractor. An accepted operation is split into
// bus_size/chunk_size chunks. One chunk is added per clock, starting at the LSB
// chunk, with a ripple carry register between chunks. The finished result and
// its flags are held until the consumer takes them.
//
// Optional feature: define SUMADOR_SAT_EN to saturate s on signed overflow.
// Saturation gives 0111..1 for a non-negative latched a and 1000..0 otherwise.
// Without the macro, s is the wrapped modulo-2^bus_size result.
//
// Handshakes: both ports are valid/ready. A transfer happens on a rising edge
// where valid && ready. A producer holds valid and its payload until that edge.
// Input side: in_valid/in_ready with payload a, b, sub. in_ready is high only
// in IDLE. Output side: out_valid/out_ready with payload s and the flags.
// out_valid is high only in DONE, and the payload is stable while it is high.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid, in_ready operation handshake
//   a, b, sub          operands (two's complement), 0 = a+b, 1 = a-b
//   out_valid, out_ready result handshake
//   s                  result
//   carry              unsigned carry-out (for subtraction 1 = no borrow)
//   overflow           signed overflow
//   zero, negative     s == 0, s[bus_size-1] (taken after any saturation)
//   busy               high in RUN or DONE
//   state_dbg          current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// -----------------------------------------------------------------------------
module sumador_serial #(
    parameter int bus_size   = 8,
    parameter int chunk_size = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bus_size-1:0] a,
    input  logic [bus_size-1:0] b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bus_size-1:0] s,
    output logic                carry,
    output logic                overflow,
    output logic                zero,
    output logic                negative,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    localparam int n_chunks = bus_size / chunk_size;
    localparam int cnt_w    = (n_chunks > 1) ? $clog2(n_chunks) : 1;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [bus_size-1:0] a_r;       // original a, also needed for saturation sign
    logic [bus_size-1:0] b_r;       // b already inverted for subtraction
    logic                cy_r;      // carry into the current chunk
    logic [cnt_w-1:0]    cnt;
    logic [bus_size-1:0] s_r;
    logic                carry_r;
    logic                ovf_r;
    logic                zero_r;
    logic                neg_r;

    logic                last_chunk;
    int                  idx;
    logic [chunk_size:0] chunk_sum;
    logic [bus_size-1:0] s_full;
    logic [bus_size-1:0] s_fin;
    logic                msb_cin;
    logic                ovf_now;

    assign last_chunk = (cnt == cnt_w'(n_chunks - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: if (in_valid)   state_nxt = st_run;
            st_run:  if (last_chunk) state_nxt = st_done;
            st_done: if (out_ready)  state_nxt = st_idle;
            default:                 state_nxt = st_idle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = (state == st_idle);
        busy      = (state != st_idle);
        out_valid = (state == st_done);
        state_dbg = state;
    end

    // One chunk of the ripple addition plus the flag terms for the last chunk
    always_comb begin
        idx       = int'(cnt) * chunk_size;
        chunk_sum = {1'b0, a_r[idx +: chunk_size]} + {1'b0, b_r[idx +: chunk_size]}
                  + {{chunk_size{1'b0}}, cy_r};
        s_full    = s_r;
        s_full[idx +: chunk_size] = chunk_sum[chunk_size-1:0];
        // The sum bit equals a^b^cin, so the MSB carry-in is recovered from it.
        msb_cin   = a_r[bus_size-1] ^ b_r[bus_size-1] ^ s_full[bus_size-1];
        ovf_now   = msb_cin ^ chunk_sum[chunk_size];
        s_fin     = s_full;
`ifdef SUMADOR_SAT_EN
        if (ovf_now) begin
            s_fin = a_r[bus_size-1] ? {1'b1, {(bus_size-1){1'b0}}}
                                    : {1'b0, {(bus_size-1){1'b1}}};
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            cy_r    <= 1'b0;
            cnt     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b ^ {bus_size{sub}};
                        cy_r <= sub;    // +1 completes the two's-complement negate
                        cnt  <= '0;
                    end
                end
                st_run: begin
                    s_r  <= s_full;
                    cy_r <= chunk_sum[chunk_size];
                    cnt  <= cnt + cnt_w'(1);
                    if (last_chunk) begin
                        s_r     <= s_fin;
                        carry_r <= chunk_sum[chunk_size];
                        ovf_r   <= ovf_now;
                        zero_r  <= (s_fin == '0);
                        neg_r   <= s_fin[bus_size-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign s        = s_r;
    assign carry    = carry_r;
    assign overflow = ovf_r;
    assign zero     = zero_r;
    assign negative = neg_r;

endmodule
